// File: rtl/led_feedback_pkg.sv
// Shared types and parameter defaults for the LED acknowledgement block.
package led_feedback_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    typedef enum logic {
        SRC_COMIDA   = 1'b0,
        SRC_MEDICINA = 1'b1
    } src_t;

    localparam int TICK_DIV_DFLT   = 12500000;
    localparam int N_COMIDA_DFLT   = 2;
    localparam int N_MEDICINA_DFLT = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_feedback_tick_divisor.sv
// Free-running divider: tick is high in the last cycle of every TICK_DIV-cycle period.
// restart forces the count back to zero so each FSM state gets a full period.
module tick_divisor
    import led_feedback_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_feedback.sv
// Blinks led2/led3 to acknowledge food/medicine button events; led1 toggles on test events.
// All outputs registered; one pending request per source is held while another sequence runs.
module led_feedback
    import led_feedback_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DFLT,
    parameter int N_COMIDA   = N_COMIDA_DFLT,
    parameter int N_MEDICINA = N_MEDICINA_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic ev_test,
    input  logic ev_comida,
    input  logic ev_medicina,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic busy
);

    localparam int            BW     = $clog2(max_int(N_COMIDA, N_MEDICINA) + 1);
    localparam logic [BW-1:0] LOAD_C = BW'(N_COMIDA);
    localparam logic [BW-1:0] LOAD_M = BW'(N_MEDICINA);

    state_t        state, state_n;
    src_t          src, src_n;
    logic [BW-1:0] blink_cnt, blink_n;
    logic          pend_c, pend_m, pend_c_n, pend_m_n;
    logic          avail_c, avail_m, start;
    logic          tick, restart;

    tick_divisor #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // A request is available if already latched or arriving this very cycle,
    // so a fresh event starts without spending a cycle in the pending flag.
    assign avail_c = pend_c | ev_comida;
    assign avail_m = pend_m | ev_medicina;

    always_comb begin
        state_n = state;
        src_n   = src;
        blink_n = blink_cnt;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (avail_c || avail_m) start = 1'b1;
            end
            ON: begin
                if (tick) begin
                    state_n = OFF;
                    blink_n = blink_cnt - BW'(1);
                end
            end
            OFF: begin
                if (tick) begin
                    if (blink_cnt != '0) begin
                        state_n = ON;
                    end else if (avail_c || avail_m) begin
                        // Chain straight into the next sequence instead of idling a cycle.
                        start = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = ON;
            src_n   = avail_m ? SRC_MEDICINA : SRC_COMIDA;
            blink_n = avail_m ? LOAD_M : LOAD_C;
        end
        pend_m_n = avail_m & ~start;
        pend_c_n = avail_c & ~(start & ~avail_m);
    end

    assign restart = (state_n != state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src       <= SRC_COMIDA;
            blink_cnt <= '0;
            pend_c    <= 1'b0;
            pend_m    <= 1'b0;
            led1      <= 1'b0;
            led2      <= 1'b0;
            led3      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            src       <= src_n;
            blink_cnt <= blink_n;
            pend_c    <= pend_c_n;
            pend_m    <= pend_m_n;
            led1      <= led1 ^ ev_test;
            led2      <= (state_n == ON) && (src_n == SRC_COMIDA);
            led3      <= (state_n == ON) && (src_n == SRC_MEDICINA);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_led_feedback.sv
// Scenario bench for led_feedback with TICK_DIV=4, N_COMIDA=2, N_MEDICINA=3.
module tb_led_feedback;

    localparam int TD = 4;
    localparam int NC = 2;
    localparam int NM = 3;

    logic clk = 1'b0;
    logic reset, ev_test, ev_comida, ev_medicina;
    logic led1, led2, led3, busy;

    int checks   = 0;
    int failures = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    led_feedback #(
        .TICK_DIV   (TD),
        .N_COMIDA   (NC),
        .N_MEDICINA (NM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_test     (ev_test),
        .ev_comida   (ev_comida),
        .ev_medicina (ev_medicina),
        .led1        (led1),
        .led2        (led2),
        .led3        (led3),
        .busy        (busy)
    );

    function automatic bit win(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

    task automatic drive(input bit r, input bit t, input bit co, input bit me);
        reset       = r;
        ev_test     = t;
        ev_comida   = co;
        ev_medicina = me;
    endtask

    // Outputs are {led1, led2, led3, busy}; cycle c output reflects inputs up to cycle c-1.
    task automatic test_idle_comida();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL idle_comida cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            drive(c <= 2, 1'b0, c == 10, 1'b0);
            n = c + 1;
            sb.push_back({1'b0, win(n, 11, 14) | win(n, 19, 22), 1'b0, win(n, 11, 26)});
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 56; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL simultaneous cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            drive(c <= 2, 1'b0, c == 10, c == 10);
            n = c + 1;
            sb.push_back({1'b0,
                          win(n, 35, 38) | win(n, 43, 46),
                          win(n, 11, 14) | win(n, 19, 22) | win(n, 27, 30),
                          win(n, 11, 50)});
        end
    endtask

    task automatic test_redundant();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL redundant cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            drive(c <= 2, 1'b0, (c == 10) || (c == 12) || (c == 15), 1'b0);
            n = c + 1;
            sb.push_back({1'b0,
                          win(n, 11, 14) | win(n, 19, 22) | win(n, 27, 30) | win(n, 35, 38),
                          1'b0, win(n, 11, 42)});
        end
    endtask

    task automatic test_test_toggle();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL test_toggle cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            drive(c <= 2, (c == 13) || (c == 20), 1'b0, c == 10);
            n = c + 1;
            sb.push_back({win(n, 14, 20), 1'b0,
                          win(n, 11, 14) | win(n, 19, 22) | win(n, 27, 30),
                          win(n, 11, 34)});
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL reset_abort cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            // Events coincident with the mid-sequence reset must be ignored.
            drive((c <= 2) || (c == 16), (c == 5) || (c == 16), c == 10, (c == 12) || (c == 16));
            n = c + 1;
            sb.push_back({win(n, 6, 16), win(n, 11, 14), 1'b0, win(n, 11, 16)});
        end
    endtask

    task automatic test_boundary();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 56; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL boundary cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            drive(c <= 2, 1'b0, c == 10, c == 26);
            n = c + 1;
            sb.push_back({1'b0,
                          win(n, 11, 14) | win(n, 19, 22),
                          win(n, 27, 30) | win(n, 35, 38) | win(n, 43, 46),
                          win(n, 11, 50)});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp, got;
        int n;
        sb.delete();
        for (int c = 0; c < 72; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                exp = sb.pop_front();
                got = {led1, led2, led3, busy};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
                end
            end
            drive(c <= 2, 1'b0, (c == 10) || (c == 12), c == 13);
            n = c + 1;
            sb.push_back({1'b0,
                          win(n, 11, 14) | win(n, 19, 22) | win(n, 51, 54) | win(n, 59, 62),
                          win(n, 27, 30) | win(n, 35, 38) | win(n, 43, 46),
                          win(n, 11, 66)});
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        test_idle_comida();
        test_simultaneous();
        test_redundant();
        test_test_toggle();
        test_reset_abort();
        test_boundary();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_feedback.md
LED_FEEDBACK -- requirements
Module: led_feedback

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12500000; clock cycles per blink half-period (250 ms at 50 MHz); legal range 2 or more.
REQ-002 The block SHALL have parameter N_COMIDA, default 2; number of blinks for a food acknowledgement.
REQ-003 The block SHALL have parameter N_MEDICINA, default 3; number of blinks for a medicine acknowledgement.
REQ-004 The block SHALL have port clk, input, 1 bit; the single system clock, with all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-006 The block SHALL have port ev_test, input, 1 bit; single-cycle pulse from the debounced test button.
REQ-007 The block SHALL have port ev_comida, input, 1 bit; single-cycle pulse from the debounced food button.
REQ-008 The block SHALL have port ev_medicina, input, 1 bit; single-cycle pulse from the debounced medicine button.
REQ-009 The block SHALL have port led1, output, 1 bit; test-mode indicator.
REQ-010 The block SHALL have port led2, output, 1 bit; food acknowledgement blink.
REQ-011 The block SHALL have port led3, output, 1 bit; medicine acknowledgement blink.
REQ-012 The block SHALL have port busy, output, 1 bit; high while a blink sequence is in progress.

Function
REQ-013 All outputs SHALL be registered; an event high in cycle n affects outputs from cycle n+1.
REQ-014 Each ev_test pulse SHALL toggle led1 in cycle n+1, in any FSM state, independent of blink activity.
REQ-015 The FSM SHALL have states IDLE, ON, OFF.
- IDLE -> ON when a request is available.
- ON -> OFF after TICK_DIV cycles.
- OFF -> ON if blinks remain, else -> IDLE, each after TICK_DIV cycles.
REQ-016 In ON, only the LED of the active source (led2 or led3) SHALL be high; in OFF and IDLE, led2 and led3 SHALL both be low.
REQ-017 A source SHALL complete exactly N_COMIDA or N_MEDICINA ON periods; sequence length = 2*N*TICK_DIV cycles; busy SHALL be high for exactly that span.
REQ-018 Each source SHALL have a one-deep pending flag, set by its event pulse and cleared when the FSM accepts it.
REQ-019 An event in IDLE with no pending request SHALL start its sequence with the LED high from cycle n+1, without an extra cycle spent pending.
REQ-020 An event for a source already pending or already active SHALL set the pending flag once; further pulses SHALL be dropped, with no counting.
REQ-021 When both requests are available in IDLE, medicina SHALL win and comida SHALL remain pending.
REQ-022 An event arriving in the last OFF cycle SHALL be latched and started in the next cycle, with no lost pulse.
REQ-023 Simultaneous ev_comida and ev_medicina in IDLE SHALL start medicina and leave comida pending.
REQ-024 The tick counter SHALL be $clog2(TICK_DIV) bits wide, count 0..TICK_DIV-1, and wrap to 0 on each state change.
REQ-025 The blink counter SHALL be $clog2(max(N_COMIDA,N_MEDICINA)+1) bits wide.

Reset
REQ-026 On reset sampled high, the FSM SHALL go to IDLE; led1, led2, led3, busy, pending flags, tick counter and blink counter SHALL be set to 0.
REQ-027 Reset mid-sequence SHALL abort the sequence immediately, with no residual pending request; events coincident with reset SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, ON, OFF) and the default values of TICK_DIV, N_COMIDA and N_MEDICINA.
REQ-029 Sub-module tick_divisor SHALL provide a one-cycle tick every TICK_DIV cycles, with a synchronous restart input driven on each FSM transition; all other logic SHALL reside in led_feedback.

Verification (TICK_DIV=4, N_COMIDA=2, N_MEDICINA=3)
REQ-030 Idle comida: ev_comida at cycle 10 -> led2 high cycles 11-14 and 19-22, low otherwise; busy high cycles 11-26.
REQ-031 Simultaneous events: ev_comida and ev_medicina at cycle 10 -> three led3 blinks (busy 11-34), then comida starts cycle 35 with led2 high 35-38.
REQ-032 Redundant pulses: ev_comida at cycles 10, 12, 15 -> exactly two comida sequences (2 blinks each), no third.
REQ-033 Test toggle mid-sequence: ev_test at 13 and 20 during a medicina sequence -> led1 high cycles 14-20, low from 21; led3 pattern unchanged.
REQ-034 Reset abort: reset at cycle 16 during a comida sequence, with medicina pending -> all outputs 0 from cycle 17; no activity until a new event.
REQ-035 Boundary: ev_medicina in the last OFF cycle of a comida sequence -> led3 high the following cycle, with no IDLE gap beyond one cycle.
